vme_cmd_sequencer: RTL and testbench
====================================

Name: vme_cmd_sequencer

Overview:
- Synthesizable, parametrised successor to the file-driven VME command stimulus.
- Replays a programmable list of VME read, write and wait commands from internal command memory onto the VME command/data registers, using the vme_cmd_rd / vme_dat_wr handshake.
- Captures read-back data into a result FIFO.
- Adds timeout detection and abort, so self-tests run in hardware as well as in simulation.

Parameters:
DATA_W, 16, width of VME data field driven/captured (1..32)
DEPTH, 64, command memory entries (power of 2)
RES_DEPTH, 16, result FIFO entries (power of 2)
CMD_MASK, 32'h00A80000, constant OR-ed into every issued vme_cmd_reg
TIMEOUT, 255, max cycles in WAIT_ACK before error

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
prog_we  in  1  write command memory entry
prog_addr  in  log2(DEPTH)  entry index
prog_data  in  18+DATA_W  entry: [17+DATA_W:16+DATA_W] opcode (00 END, 01 WRITE, 10 READ, 11 WAIT); [15+DATA_W:16] data or wait count; [15:0] VME instruction
go  in  1  start sequence at entry 0
abort  in  1  stop sequence
vme_cmd_rd  in  1  VME side ready for next command
vme_dat_wr  in  1  VME side completed current command
vme_dat_reg_out  in  32  VME read-back data
start  out  1  one-cycle command strobe
vme_cmd_reg  out  32  command word
vme_dat_reg_in  out  32  write data, zero-extended from DATA_W
busy  out  1  sequence running
done  out  1  one-cycle pulse at sequence end
err_timeout  out  1  sticky: last sequence timed out
res_rd  in  1  pop result FIFO
res_data  out  16+DATA_W  {instruction, read data}, first-word-fall-through
res_empty  out  1  FIFO empty
res_ovf  out  1  sticky: read result dropped on full FIFO

Behaviour:
Reset (async) values:
- start=0, vme_cmd_reg=CMD_MASK, vme_dat_reg_in=0, busy=0, done=0, err_timeout=0, res_ovf=0.
- FIFO empty; state IDLE; pc=0.
- Command memory contents are not reset.

Command memory:
- Written only while busy=0; prog_we while busy is ignored.
- Read is synchronous (1 cycle).

FSM:
- IDLE: go=1 -> pc=0, err_timeout cleared, busy=1 next cycle, go to FETCH. go while busy is ignored.
- FETCH: read mem[pc] -> DECODE.
- DECODE: END -> DONE. WAIT -> DELAY, count=data. READ/WRITE -> WAIT_RDY.
- WAIT_RDY: on the cycle vme_cmd_rd=1, register the outputs for exactly one cycle:
  - start=1.
  - vme_cmd_reg = {16'h0, instruction} | CMD_MASK, plus bit25=1 for READ or bit24=1 for WRITE.
  - vme_dat_reg_in = data (WRITE) or 0 (READ).
  - Next state WAIT_ACK, timer=0.
- WAIT_ACK: outputs return to idle values (start=0, cmd=CMD_MASK, dat=0).
  - vme_dat_wr=1 -> if READ, push {instruction, vme_dat_reg_out[DATA_W-1:0]}; then pc+1 -> FETCH.
  - timer==TIMEOUT without vme_dat_wr -> err_timeout=1, go to DONE.
  - vme_dat_wr in the same cycle timer reaches TIMEOUT counts as success.
- DELAY: decrement each cycle; exits to FETCH (pc+1) on the cycle count==0. A count of 0 yields a one-cycle DELAY.
- DONE: done=1 for one cycle, busy=0, -> IDLE.

Wrap and abort:
- pc==DEPTH-1 completing a non-END command -> DONE; no wrap-around.
- abort=1 in any non-IDLE state -> IDLE next cycle. Outputs go to reset values except FIFO contents and sticky flags. done is not pulsed.
- abort has priority over go in the same cycle.

Result FIFO:
- res_data is valid whenever res_empty=0; res_rd pops.
- res_rd while empty is ignored.
- Push when full and no pop: data dropped, res_ovf=1 (sticky until rst or go).
- Push and pop in the same cycle when full: both succeed, no overflow.
- Throughput: one command per 3 cycles minimum (FETCH, DECODE, WAIT_RDY) plus ack latency.

Test Plan:
1. Program [WRITE 0x4100 data 0x00FF, READ 0x4200, END]; go; vme_cmd_rd=1; vme_dat_wr 2 cycles after each start; vme_dat_reg_out=0x1234 -> cmd words 0x01A84100 / dat 0x00FF, then 0x02A84200; FIFO holds {0x4200,0x1234}; one done pulse.
2. Hold vme_cmd_rd=0 for 20 cycles after DECODE -> start stays 0 and busy=1; raise it -> start pulses exactly once.
3. READ with no vme_dat_wr, TIMEOUT=255 -> err_timeout=1 at cycle 256 of WAIT_ACK; done pulses; FIFO unchanged.
4. WAIT 10 between two WRITEs -> second start occurs ≥13 cycles after first ack; WAIT 0 -> single delay cycle.
5. 17 READs with RES_DEPTH=16 and no res_rd -> 16 entries kept, res_ovf=1. Repeat with res_rd asserted on the 17th push -> res_ovf=0.
6. abort during WAIT_ACK, and rst asserted mid-DELAY -> outputs at idle values next cycle (rst: immediately). busy=0, no done. A subsequent go replays from entry 0.

Source files
------------

// File: rtl/vme_cmd_sequencer.sv
// Replays a programmed list of VME read/write/wait commands over the vme_cmd_rd/vme_dat_wr
// handshake, with an ack timeout and a first-word-fall-through FIFO for read-back results.
module vme_cmd_sequencer #(
    parameter int          DATA_W    = 16,
    parameter int          DEPTH     = 64,
    parameter int          RES_DEPTH = 16,
    parameter logic [31:0] CMD_MASK  = 32'h00A80000,
    parameter int          TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [17+DATA_W:0]       prog_data,
    input  logic                     go,
    input  logic                     abort,
    input  logic                     vme_cmd_rd,
    input  logic                     vme_dat_wr,
    input  logic [31:0]              vme_dat_reg_out,
    output logic                     start,
    output logic [31:0]              vme_cmd_reg,
    output logic [31:0]              vme_dat_reg_in,
    output logic                     busy,
    output logic                     done,
    output logic                     err_timeout,
    input  logic                     res_rd,
    output logic [15+DATA_W:0]       res_data,
    output logic                     res_empty,
    output logic                     res_ovf
);

    // state    | meaning
    // IDLE     | waiting for go
    // FETCH    | synchronous read of mem[pc]
    // DECODE   | dispatch on opcode
    // WAIT_RDY | waiting for vme_cmd_rd, then strobe the command
    // WAIT_ACK | waiting for vme_dat_wr, timer running
    // DELAY    | counting down a WAIT command
    // DONE     | sequence end, done pulses next cycle

    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(RES_DEPTH);
    localparam int PW = RW + 1;
    localparam int EW = 18 + DATA_W;
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] OP_END   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WAIT  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_WAIT_RDY, S_WAIT_ACK, S_DELAY, S_DONE
    } state_t;

    state_t              state;
    logic [EW-1:0]       mem [DEPTH];
    logic [EW-1:0]       cur;
    logic [AW-1:0]       pc;
    logic [TW-1:0]       timer;
    logic [DATA_W-1:0]   count;
    logic [15+DATA_W:0]  res_mem [RES_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;

    logic [1:0]          cur_op;
    logic [DATA_W-1:0]   cur_data;
    logic [15:0]         cur_instr;
    logic [31:0]         cmd_word;
    logic [31:0]         dat_ext;
    logic                last;
    logic                go_accept;
    logic                push;
    logic                pop;
    logic                full;
    logic                rd_unused;

    assign cur_op    = cur[EW-1:EW-2];
    assign cur_data  = cur[15+DATA_W:16];
    assign cur_instr = cur[15:0];
    assign last      = (pc == AW'(DEPTH - 1));
    assign go_accept = (state == S_IDLE) && go && !abort;
    assign rd_unused = ^vme_dat_reg_out;

    always_comb begin
        cmd_word = CMD_MASK | {16'h0000, cur_instr};
        if (cur_op == OP_READ)
            cmd_word[25] = 1'b1;
        else
            cmd_word[24] = 1'b1;
        dat_ext = '0;
        dat_ext[DATA_W-1:0] = cur_data;
    end

    always_ff @(posedge clk) begin
        if (prog_we && !busy)
            mem[prog_addr] <= prog_data;
        if (state == S_FETCH)
            cur <= mem[pc];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            pc             <= '0;
            timer          <= '0;
            count          <= '0;
            start          <= 1'b0;
            vme_cmd_reg    <= CMD_MASK;
            vme_dat_reg_in <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            start          <= 1'b0;
            done           <= 1'b0;
            vme_cmd_reg    <= CMD_MASK;
            vme_dat_reg_in <= '0;
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
                pc    <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (go_accept) begin
                            pc          <= '0;
                            err_timeout <= 1'b0;
                            busy        <= 1'b1;
                            state       <= S_FETCH;
                        end
                    end
                    S_FETCH: state <= S_DECODE;
                    S_DECODE: begin
                        case (cur_op)
                            OP_END:  state <= S_DONE;
                            OP_WAIT: begin
                                count <= cur_data;
                                state <= S_DELAY;
                            end
                            default: state <= S_WAIT_RDY;
                        endcase
                    end
                    S_WAIT_RDY: begin
                        if (vme_cmd_rd) begin
                            start          <= 1'b1;
                            vme_cmd_reg    <= cmd_word;
                            vme_dat_reg_in <= (cur_op == OP_WRITE) ? dat_ext : '0;
                            timer          <= TW'(TIMEOUT);
                            state          <= S_WAIT_ACK;
                        end
                    end
                    S_WAIT_ACK: begin
                        // an ack in the terminal timer cycle still wins over the timeout
                        if (vme_dat_wr) begin
                            if (last) state <= S_DONE;
                            else begin
                                pc    <= pc + AW'(1);
                                state <= S_FETCH;
                            end
                        end else if (timer == '0) begin
                            err_timeout <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    S_DELAY: begin
                        if (count == '0) begin
                            if (last) state <= S_DONE;
                            else begin
                                pc    <= pc + AW'(1);
                                state <= S_FETCH;
                            end
                        end else begin
                            count <= count - DATA_W'(1);
                        end
                    end
                    S_DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign push      = (state == S_WAIT_ACK) && vme_dat_wr && (cur_op == OP_READ) && !abort;
    assign res_empty = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[RW-1:0] == rd_ptr[RW-1:0]) && (wr_ptr[RW] != rd_ptr[RW]);
    assign pop       = res_rd && !res_empty;
    assign res_data  = res_mem[rd_ptr[RW-1:0]];

    always_ff @(posedge clk) begin
        if (push && (!full || pop))
            res_mem[wr_ptr[RW-1:0]] <= {cur_instr, vme_dat_reg_out[DATA_W-1:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            res_ovf <= 1'b0;
        end else begin
            if (push && (!full || pop))
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (go_accept)
                res_ovf <= 1'b0;
            else if (push && full && !pop)
                res_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vme_cmd_sequencer.sv
// Directed bench for vme_cmd_sequencer: a VME responder process acks each start after a
// programmable delay and logs every issued command for the scenario tasks to inspect.
module tb_vme_cmd_sequencer;

    localparam logic [31:0] MASK = 32'h00A80000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_we = 1'b0;
    logic [5:0]  prog_addr = '0;
    logic [33:0] prog_data = '0;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic        vme_cmd_rd = 1'b0;
    logic        vme_dat_wr = 1'b0;
    logic [31:0] vme_dat_reg_out = '0;
    logic        start;
    logic [31:0] vme_cmd_reg;
    logic [31:0] vme_dat_reg_in;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic        res_rd = 1'b0;
    logic [31:0] res_data;
    logic        res_empty;
    logic        res_ovf;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    int          n_starts = 0;
    int          n_done = 0;
    int          n_acks = 0;
    int          pop_at = -1;
    int          pending = 0;
    bit          ack_en = 1'b1;
    int          ack_delay = 2;
    bit          mon_pop = 1'b0;
    logic [31:0] cmd_log [32];
    logic [31:0] dat_log [32];
    int          start_cyc [32];

    vme_cmd_sequencer dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .go(go), .abort(abort), .vme_cmd_rd(vme_cmd_rd), .vme_dat_wr(vme_dat_wr),
        .vme_dat_reg_out(vme_dat_reg_out), .start(start), .vme_cmd_reg(vme_cmd_reg),
        .vme_dat_reg_in(vme_dat_reg_in), .busy(busy), .done(done), .err_timeout(err_timeout),
        .res_rd(res_rd), .res_data(res_data), .res_empty(res_empty), .res_ovf(res_ovf)
    );

    always #5 clk = ~clk;

    // VME responder and logger, all activity on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (vme_dat_wr) vme_dat_wr = 1'b0;
            if (mon_pop) begin res_rd = 1'b0; mon_pop = 1'b0; end
            if (rst) pending = 0;
            else if (start) begin
                if (n_starts < 32) begin
                    cmd_log[n_starts] = vme_cmd_reg;
                    dat_log[n_starts] = vme_dat_reg_in;
                    start_cyc[n_starts] = cyc;
                end
                n_starts++;
                if (ack_en) pending = ack_delay;
            end else if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    vme_dat_wr = 1'b1;
                    if (n_acks == pop_at) begin res_rd = 1'b1; mon_pop = 1'b1; end
                    n_acks++;
                end
            end
            if (done) n_done++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic prog(input int a, input logic [1:0] op, input logic [15:0] d, input logic [15:0] ins);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 6'(a); prog_data = {op, d, ins};
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic pulse_go();
        @(negedge clk); go = 1'b1;
        @(negedge clk); go = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk); res_rd = 1'b1;
        @(negedge clk); res_rd = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic wait_start(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (start) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %0h expected 0", start); end
        checks++; if (vme_cmd_reg !== MASK) begin errors++; $display("FAIL reset_cmd: got %h expected %h", vme_cmd_reg, MASK); end
        checks++; if (vme_dat_reg_in !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h expected 0", vme_dat_reg_in); end
        checks++; if ({busy, done, err_timeout, res_ovf} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, err_timeout, res_ovf}); end
        checks++; if (res_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0h expected 1", res_empty); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit seen;
        int d0;
        prog(0, 2'b01, 16'h00FF, 16'h4100);
        prog(1, 2'b10, 16'h0000, 16'h4200);
        prog(2, 2'b00, 16'h0000, 16'h0000);
        vme_cmd_rd = 1'b1; vme_dat_reg_out = 32'hFFFF1234; ack_en = 1'b1; ack_delay = 2;
        n_starts = 0; d0 = n_done;
        pulse_go();
        wait_done(100, seen);
        repeat (3) @(negedge clk);
        checks++; if (!seen) begin errors++; $display("FAIL basic_done: got no done expected done pulse"); end
        checks++; if (n_starts !== 2) begin errors++; $display("FAIL basic_starts: got %0d expected 2", n_starts); end
        checks++; if (cmd_log[0] !== 32'h01A84100) begin errors++; $display("FAIL basic_cmd0: got %h expected 01a84100", cmd_log[0]); end
        checks++; if (dat_log[0] !== 32'h000000FF) begin errors++; $display("FAIL basic_dat0: got %h expected 000000ff", dat_log[0]); end
        checks++; if (cmd_log[1] !== 32'h02A84200) begin errors++; $display("FAIL basic_cmd1: got %h expected 02a84200", cmd_log[1]); end
        checks++; if (dat_log[1] !== 32'h0) begin errors++; $display("FAIL basic_dat1: got %h expected 0", dat_log[1]); end
        checks++; if (start_cyc[1] - start_cyc[0] !== 6) begin errors++; $display("FAIL basic_spacing: got %0d expected 6", start_cyc[1] - start_cyc[0]); end
        checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", n_done - d0); end
        checks++; if (res_empty !== 1'b0 || res_data !== 32'h42001234) begin errors++; $display("FAIL basic_fifo: got empty=%0h data=%h expected 0 42001234", res_empty, res_data); end
        checks++; if (busy !== 1'b0 || vme_cmd_reg !== MASK) begin errors++; $display("FAIL basic_idle: got busy=%0h cmd=%h expected 0 %h", busy, vme_cmd_reg, MASK); end
        pop_one();
        checks++; if (res_empty !== 1'b1) begin errors++; $display("FAIL basic_pop: got empty=%0h expected 1", res_empty); end
    endtask

    task automatic test_rdy_hold();
        bit seen;
        prog(0, 2'b01, 16'h0005, 16'h4300);
        prog(1, 2'b00, 16'h0000, 16'h0000);
        vme_cmd_rd = 1'b0; n_starts = 0;
        pulse_go();
        repeat (4) @(negedge clk);
        prog(1, 2'b01, 16'h0007, 16'h4F00);
        repeat (20) @(negedge clk);
        checks++; if (n_starts !== 0) begin errors++; $display("FAIL hold_nostart: got %0d starts expected 0", n_starts); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %0h expected 1", busy); end
        vme_cmd_rd = 1'b1;
        wait_done(50, seen);
        checks++; if (!seen || n_starts !== 1) begin errors++; $display("FAIL hold_once: got done=%0d starts=%0d expected 1 1", seen, n_starts); end
        checks++; if (cmd_log[0] !== 32'h01A84300 || dat_log[0] !== 32'h5) begin errors++; $display("FAIL hold_cmd: got %h/%h expected 01a84300/00000005", cmd_log[0], dat_log[0]); end
    endtask

    task automatic test_timeout();
        bit seen;
        prog(0, 2'b10, 16'h0000, 16'h4400);
        prog(1, 2'b00, 16'h0000, 16'h0000);
        ack_en = 1'b0;
        pulse_go();
        wait_start(20, seen);
        checks++; if (!seen) begin errors++; $display("FAIL to_start: got no start expected start"); end
        repeat (255) @(negedge clk);
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_early: got %0h expected 0 at ack cycle 255", err_timeout); end
        @(negedge clk);
        checks++; if (err_timeout !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL to_flag: got err=%0h busy=%0h expected 1 1", err_timeout, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_done: got done=%0h busy=%0h expected 1 0", done, busy); end
        checks++; if (res_empty !== 1'b1) begin errors++; $display("FAIL to_fifo: got empty=%0h expected 1", res_empty); end
        ack_en = 1'b1;
    endtask

    task automatic test_wait_cmd();
        bit seen;
        prog(0, 2'b01, 16'h0001, 16'h4500);
        prog(1, 2'b11, 16'd10,   16'h0000);
        prog(2, 2'b01, 16'h0002, 16'h4501);
        prog(3, 2'b11, 16'd0,    16'h0000);
        prog(4, 2'b01, 16'h0003, 16'h4502);
        prog(5, 2'b00, 16'h0000, 16'h0000);
        n_starts = 0;
        pulse_go();
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL wait_errclr: got %0h expected 0", err_timeout); end
        wait_done(150, seen);
        checks++; if (!seen || n_starts !== 3) begin errors++; $display("FAIL wait_run: got done=%0d starts=%0d expected 1 3", seen, n_starts); end
        checks++; if (start_cyc[1] - start_cyc[0] !== 19) begin errors++; $display("FAIL wait_10: got %0d expected 19", start_cyc[1] - start_cyc[0]); end
        checks++; if (start_cyc[2] - start_cyc[1] !== 9) begin errors++; $display("FAIL wait_0: got %0d expected 9", start_cyc[2] - start_cyc[1]); end
        checks++; if (dat_log[2] !== 32'h3 || cmd_log[2] !== 32'h01A84502) begin errors++; $display("FAIL wait_cmd2: got %h/%h expected 01a84502/00000003", cmd_log[2], dat_log[2]); end
    endtask

    task automatic test_overflow();
        bit seen;
        int cnt;
        logic [15:0] ins;
        for (int i = 0; i < 17; i++) prog(i, 2'b10, 16'h0000, 16'h4600 + 16'(i));
        prog(17, 2'b00, 16'h0000, 16'h0000);
        vme_dat_reg_out = 32'h0000ABCD;
        pulse_go();
        wait_done(300, seen);
        checks++; if (!seen || res_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got done=%0d ovf=%0h expected 1 1", seen, res_ovf); end
        for (int i = 0; i < 16; i++) begin
            ins = 16'h4600 + 16'(i);
            checks++; if (res_empty !== 1'b0 || res_data !== {ins, 16'hABCD}) begin errors++; $display("FAIL ovf_entry%0d: got empty=%0h data=%h expected 0 %h", i, res_empty, res_data, {ins, 16'hABCD}); end
            pop_one();
        end
        checks++; if (res_empty !== 1'b1) begin errors++; $display("FAIL ovf_drained: got %0h expected 1", res_empty); end
        n_acks = 0; pop_at = 16;
        pulse_go();
        @(negedge clk);
        checks++; if (res_ovf !== 1'b0) begin errors++; $display("FAIL ovf_goclr: got %0h expected 0", res_ovf); end
        wait_done(300, seen);
        pop_at = -1;
        checks++; if (!seen || res_ovf !== 1'b0) begin errors++; $display("FAIL ovf_poppush: got done=%0d ovf=%0h expected 1 0", seen, res_ovf); end
        checks++; if (res_data !== 32'h4601ABCD) begin errors++; $display("FAIL ovf_head: got %h expected 4601abcd", res_data); end
        cnt = 0;
        for (int i = 0; i < 20 && res_empty === 1'b0; i++) begin
            if (cnt == 15) begin
                checks++; if (res_data !== 32'h4610ABCD) begin errors++; $display("FAIL ovf_tail: got %h expected 4610abcd", res_data); end
            end
            pop_one();
            cnt++;
        end
        checks++; if (cnt !== 16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", cnt); end
    endtask

    task automatic test_abort();
        bit seen;
        int d0;
        prog(0, 2'b10, 16'h0000, 16'h4700);
        prog(1, 2'b11, 16'd20,   16'h0000);
        prog(2, 2'b01, 16'h0009, 16'h4701);
        prog(3, 2'b00, 16'h0000, 16'h0000);
        ack_en = 1'b0; d0 = n_done;
        pulse_go();
        wait_start(20, seen);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++; if (!seen || busy !== 1'b0 || start !== 1'b0) begin errors++; $display("FAIL abort_idle: got started=%0d busy=%0h start=%0h expected 1 0 0", seen, busy, start); end
        checks++; if (vme_cmd_reg !== MASK || vme_dat_reg_in !== 32'h0) begin errors++; $display("FAIL abort_outs: got %h/%h expected %h/0", vme_cmd_reg, vme_dat_reg_in, MASK); end
        repeat (5) @(negedge clk);
        checks++; if (n_done !== d0 || res_empty !== 1'b1) begin errors++; $display("FAIL abort_nodone: got dones=%0d empty=%0h expected 0 1", n_done - d0, res_empty); end
        @(negedge clk); go = 1'b1; abort = 1'b1;
        @(negedge clk); go = 1'b0; abort = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_prio: got busy=%0h expected 0", busy); end
        ack_en = 1'b1; vme_dat_reg_out = 32'h00005A5A;
        pulse_go();
        wait_start(20, seen);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || start !== 1'b0 || vme_cmd_reg !== MASK) begin errors++; $display("FAIL rst_mid: got busy=%0h start=%0h cmd=%h expected 0 0 %h", busy, start, vme_cmd_reg, MASK); end
        checks++; if (res_empty !== 1'b1) begin errors++; $display("FAIL rst_fifo: got empty=%0h expected 1", res_empty); end
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (n_done !== d0) begin errors++; $display("FAIL rst_nodone: got %0d dones expected 0", n_done - d0); end
        n_starts = 0;
        pulse_go();
        wait_done(150, seen);
        checks++; if (!seen || n_starts !== 2) begin errors++; $display("FAIL replay_run: got done=%0d starts=%0d expected 1 2", seen, n_starts); end
        checks++; if (cmd_log[0] !== 32'h02A84700 || cmd_log[1] !== 32'h01A84701 || dat_log[1] !== 32'h9) begin errors++; $display("FAIL replay_cmds: got %h %h %h expected 02a84700 01a84701 00000009", cmd_log[0], cmd_log[1], dat_log[1]); end
        checks++; if (res_data !== 32'h47005A5A) begin errors++; $display("FAIL replay_fifo: got %h expected 47005a5a", res_data); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rdy_hold();
        test_timeout();
        test_wait_cmd();
        test_overflow();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
